// File: rtl/untrap_sequencer_pkg.sv
// Shared definitions for the trap-exit sequencer: FSM encoding, exit opcodes, status bits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package untrap_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_PREFIX  = 3'd2,
        ST_OPERAND = 3'd3,
        ST_UNTRAP  = 3'd4
    } state_t;

    localparam logic [7:0] OP_RET  = 8'hC9;
    localparam logic [7:0] OP_JP   = 8'hC3;
    localparam logic [7:0] OP_JPHL = 8'hE9;
    localparam logic [7:0] OP_ED   = 8'hED;
    localparam logic [7:0] OP_RETN = 8'h45;
    localparam logic [7:0] OP_RETI = 8'h4D;

    localparam int STAT_ARMED   = 0;
    localparam int STAT_PENDING = 1;
    localparam int STAT_TIMEOUT = 2;

    localparam logic [7:0] CTRL_PORT_DEF  = 8'h40;
    localparam int         TIMEOUT_M1_DEF = 64;
    localparam int         TW_DEF         = 7;

    // States in which the handler is running and the watchdog is live.
    function automatic logic is_armed(state_t s);
        return (s == ST_ARMED) || (s == ST_PREFIX) || (s == ST_OPERAND);
    endfunction

endpackage

// File: rtl/untrap_sequencer_if.sv
// Z80 bus view plus trap-controller handshake for the trap-exit sequencer.
// Latency: n/a (wiring only).
// Backpressure: none; the CPU bus cannot be stalled from here.
interface untrap_sequencer_if;
    logic       m1_n;
    logic       mreq_n;
    logic       iorq_n;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] addr_lo;
    logic [7:0] data_in;
    logic       trap_state;
    logic       virtual_enabled;
    logic       last_isr_untrap;
    logic [7:0] status_q;
    logic       status_oe;

    modport master (
        output m1_n, mreq_n, iorq_n, rd_n, wr_n, addr_lo, data_in,
        output trap_state, virtual_enabled,
        input  last_isr_untrap, status_q, status_oe
    );

    modport slave (
        input  m1_n, mreq_n, iorq_n, rd_n, wr_n, addr_lo, data_in,
        input  trap_state, virtual_enabled,
        output last_isr_untrap, status_q, status_oe
    );
endinterface

// File: rtl/untrap_sequencer_bus_strobe_detect.sv
// Turns Z80 control-line edges into single-cycle strobes (ctrl write, opcode fetch, mem read, M1 fall).
// Latency: strobe is high in the cycle the edge is first sampled; prior level is one register deep.
// Backpressure: none; every qualifying edge produces exactly one strobe.
module untrap_sequencer_bus_strobe_detect #(
    parameter logic [7:0] CTRL_PORT = 8'h40
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m1_n,
    input  logic       mreq_n,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    input  logic [7:0] addr_lo,
    output logic       ctrl_wr,
    output logic       op_fetch,
    output logic       mem_rd,
    output logic       m1_fall
);
    logic m1_q, rd_q, wr_q;
    logic rd_rise, wr_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1_q <= 1'b1;
            rd_q <= 1'b1;
            wr_q <= 1'b1;
        end else begin
            m1_q <= m1_n;
            rd_q <= rd_n;
            wr_q <= wr_n;
        end
    end

    // Data is valid on the bus while RD is still low, so the rising edge is the capture point.
    assign rd_rise  = ~rd_q & rd_n;
    assign wr_fall  = wr_q & ~wr_n;
    assign m1_fall  = m1_q & ~m1_n;

    assign ctrl_wr  = wr_fall & ~iorq_n & m1_n & (addr_lo == CTRL_PORT);
    assign op_fetch = rd_rise & ~m1_n & ~mreq_n;
    assign mem_rd   = rd_rise &  m1_n & ~mreq_n;
endmodule

// File: rtl/untrap_sequencer.sv
// Watches a trap handler's fetch stream and flags completion of its exit instruction to the trap controller.
// Latency: last_isr_untrap rises on the clk edge that samples the final byte of the exit instruction.
// Backpressure: none; a handler that never exits is dropped by a watchdog after TIMEOUT_M1 M1 cycles.
module untrap_sequencer
    import untrap_sequencer_pkg::*;
#(
    parameter logic [7:0] CTRL_PORT  = CTRL_PORT_DEF,
    parameter int         TIMEOUT_M1 = TIMEOUT_M1_DEF,
    parameter int         TW         = TW_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    untrap_sequencer_if.slave  bus
);
    localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_M1 - 1);

    state_t        state;
    logic [TW-1:0] wd;
    logic [1:0]    cnt;
    logic          last_q;
    logic          timeout_err;
    logic          ctrl_wr, op_fetch, mem_rd, m1_fall;
    logic          active, in_trap, wd_expire;
    logic [7:0]    status;

    untrap_sequencer_bus_strobe_detect #(.CTRL_PORT(CTRL_PORT)) u_strobe (
        .clk      (clk),
        .rst_n    (rst_n),
        .m1_n     (bus.m1_n),
        .mreq_n   (bus.mreq_n),
        .iorq_n   (bus.iorq_n),
        .rd_n     (bus.rd_n),
        .wr_n     (bus.wr_n),
        .addr_lo  (bus.addr_lo),
        .ctrl_wr  (ctrl_wr),
        .op_fetch (op_fetch),
        .mem_rd   (mem_rd),
        .m1_fall  (m1_fall)
    );

    assign active    = is_armed(state);
    assign in_trap   = bus.virtual_enabled & bus.trap_state;
    // An external abort (virtualization off or trap dropped) outranks the watchdog: no error then.
    assign wd_expire = active & in_trap & m1_fall & (wd == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            wd          <= '0;
            cnt         <= '0;
            last_q      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (wd_expire)
                timeout_err <= 1'b1;
            if (ctrl_wr && bus.data_in[1])
                timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (ctrl_wr && bus.data_in[0] && bus.trap_state) begin
                        state <= ST_ARMED;
                        wd    <= '0;
                    end
                end
                ST_ARMED, ST_PREFIX, ST_OPERAND: begin
                    if (!in_trap || wd_expire) begin
                        state <= ST_IDLE;
                    end else begin
                        if (m1_fall && (wd != '1))
                            wd <= wd + 1'b1;
                        if (op_fetch) begin
                            if (state == ST_ARMED) begin
                                case (bus.data_in)
                                    OP_RET, OP_JPHL: begin
                                        state  <= ST_UNTRAP;
                                        last_q <= 1'b1;
                                    end
                                    OP_JP: begin
                                        state <= ST_OPERAND;
                                        cnt   <= 2'd2;
                                    end
                                    OP_ED:   state <= ST_PREFIX;
                                    default: state <= ST_ARMED;
                                endcase
                            end else if (state == ST_PREFIX &&
                                         (bus.data_in == OP_RETN || bus.data_in == OP_RETI)) begin
                                state  <= ST_UNTRAP;
                                last_q <= 1'b1;
                            end else begin
                                state <= ST_ARMED;
                            end
                        end else if (mem_rd && state == ST_OPERAND) begin
                            cnt <= cnt - 2'd1;
                            if (cnt == 2'd1) begin
                                state  <= ST_UNTRAP;
                                last_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_UNTRAP: begin
                    if (!in_trap) begin
                        state  <= ST_IDLE;
                        last_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    last_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        status               = '0;
        status[STAT_ARMED]   = active;
        status[STAT_PENDING] = (state == ST_UNTRAP);
        status[STAT_TIMEOUT] = timeout_err;
    end

    assign bus.last_isr_untrap = last_q;
    assign bus.status_q        = status;
    assign bus.status_oe       = ~bus.iorq_n & ~bus.rd_n & bus.m1_n & (bus.addr_lo == CTRL_PORT);
endmodule

// File: tb/tb_untrap_sequencer.sv
// Directed bench for untrap_sequencer: opcode table plus hand sequences for operand, watchdog, abort, reset.
// Latency: checks sample on the falling clk edge, half a cycle after the DUT updates.
// Backpressure: n/a.
module tb_untrap_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    untrap_sequencer_if bus();

    untrap_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] op1;
        logic [7:0] op2;
        bit         two;
        logic [7:0] exp_st;
        logic       exp_last;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
        bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic fetch(input logic [7:0] op);
        @(negedge clk);
        bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.data_in = op;
        @(negedge clk);
        @(negedge clk);
        bus.rd_n = 1'b1;
        @(negedge clk);
        bus.m1_n = 1'b1; bus.mreq_n = 1'b1;
    endtask

    task automatic mem_read(input logic [7:0] d);
        @(negedge clk);
        bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.data_in = d;
        @(negedge clk);
        bus.rd_n = 1'b1;
        @(negedge clk);
        bus.mreq_n = 1'b1;
    endtask

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.iorq_n = 1'b0; bus.addr_lo = a; bus.data_in = d; bus.wr_n = 1'b0;
        @(negedge clk);
        bus.wr_n = 1'b1;
        @(negedge clk);
        bus.iorq_n = 1'b1;
    endtask

    task automatic settle_chk(input string nm, input logic [7:0] st, input logic last);
        @(negedge clk);
        chk({nm, "_status"}, bus.status_q, st);
        chk({nm, "_last"}, {7'b0, bus.last_isr_untrap}, {7'b0, last});
    endtask

    task automatic drop_trap();
        @(negedge clk);
        bus.trap_state = 1'b0;
        cyc(2);
        bus.trap_state = 1'b1;
    endtask

    initial begin
        vecs[0]  = '{8'hC9, 8'h00, 1'b0, 8'h02, 1'b1};
        vecs[1]  = '{8'hE9, 8'h00, 1'b0, 8'h02, 1'b1};
        vecs[2]  = '{8'h00, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[3]  = '{8'hED, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[4]  = '{8'hC3, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[5]  = '{8'hED, 8'h4D, 1'b1, 8'h02, 1'b1};
        vecs[6]  = '{8'hED, 8'h45, 1'b1, 8'h02, 1'b1};
        vecs[7]  = '{8'hED, 8'hB0, 1'b1, 8'h01, 1'b0};
        vecs[8]  = '{8'hC3, 8'hC9, 1'b1, 8'h01, 1'b0};
        vecs[9]  = '{8'h4D, 8'h00, 1'b0, 8'h01, 1'b0};
        vecs[10] = '{8'hED, 8'hC9, 1'b1, 8'h01, 1'b0};

        bus_idle();
        bus.addr_lo = 8'h00; bus.data_in = 8'h00;
        bus.trap_state = 1'b1; bus.virtual_enabled = 1'b1;
        cyc(3);
        chk("reset_status", bus.status_q, 8'h00);
        chk("reset_last", {7'b0, bus.last_isr_untrap}, 8'h00);
        chk("reset_oe", {7'b0, bus.status_oe}, 8'h00);
        rst_n = 1'b1;
        cyc(2);

        // Opcode table: arm, fetch one or two opcodes, check, then let the controller drop trap.
        for (int i = 0; i < 11; i++) begin
            io_write(8'h40, 8'h01);
            chk($sformatf("vec%0d_armed", i), bus.status_q, 8'h01);
            fetch(vecs[i].op1);
            if (vecs[i].two) fetch(vecs[i].op2);
            settle_chk($sformatf("vec%0d", i), vecs[i].exp_st, vecs[i].exp_last);
            drop_trap();
            settle_chk($sformatf("vec%0d_exit", i), 8'h00, 1'b0);
        end

        // RET: untrap holds while trap_state stays high, clears on the edge it samples low.
        io_write(8'h40, 8'h01);
        fetch(8'hC9);
        cyc(4);
        chk("ret_hold", {7'b0, bus.last_isr_untrap}, 8'h01);
        bus.trap_state = 1'b0;
        @(negedge clk);
        chk("ret_clear_last", {7'b0, bus.last_isr_untrap}, 8'h00);
        chk("ret_clear_status", bus.status_q, 8'h00);
        bus.trap_state = 1'b1;

        // JP nn: untrap only after the second operand read.
        io_write(8'h40, 8'h01);
        fetch(8'hC3);
        mem_read(8'h00);
        settle_chk("jp_op1", 8'h01, 1'b0);
        mem_read(8'h80);
        settle_chk("jp_op2", 8'h02, 1'b1);
        drop_trap();

        // Watchdog: 63 M1 cycles still armed, the 64th times out.
        io_write(8'h40, 8'h01);
        for (int i = 0; i < 63; i++) fetch(8'h00);
        settle_chk("wd_63", 8'h01, 1'b0);
        fetch(8'h00);
        settle_chk("wd_64", 8'h04, 1'b0);
        io_write(8'h41, 8'h02);
        settle_chk("wd_wrong_port", 8'h04, 1'b0);
        io_write(8'h40, 8'h02);
        settle_chk("wd_cleared", 8'h00, 1'b0);

        // Arm ignored outside trap; virtualization off aborts silently.
        bus.trap_state = 1'b0;
        io_write(8'h40, 8'h01);
        settle_chk("arm_no_trap", 8'h00, 1'b0);
        bus.trap_state = 1'b1;
        io_write(8'h40, 8'h01);
        settle_chk("arm_ok", 8'h01, 1'b0);
        bus.virtual_enabled = 1'b0;
        @(negedge clk);
        chk("virt_off_status", bus.status_q, 8'h00);
        fetch(8'hC9);
        settle_chk("virt_off_ret", 8'h00, 1'b0);
        bus.virtual_enabled = 1'b1;

        // External untrap while armed: back to idle with no error.
        io_write(8'h40, 8'h01);
        fetch(8'hED);
        drop_trap();
        settle_chk("ext_untrap", 8'h00, 1'b0);

        // Async reset in OPERAND clears outputs without waiting for a clock.
        io_write(8'h40, 8'h01);
        fetch(8'hC3);
        mem_read(8'h00);
        settle_chk("pre_reset", 8'h01, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_status", bus.status_q, 8'h00);
        chk("rst_async_last", {7'b0, bus.last_isr_untrap}, 8'h00);
        cyc(2);
        rst_n = 1'b1;
        mem_read(8'h80);
        settle_chk("post_reset", 8'h00, 1'b0);

        // IN (40h): status_oe only for an I/O read with M1 high at the control port.
        @(negedge clk);
        bus.iorq_n = 1'b0; bus.rd_n = 1'b0; bus.addr_lo = 8'h40;
        #1;
        chk("in_oe", {7'b0, bus.status_oe}, 8'h01);
        chk("in_data", bus.status_q, 8'h00);
        bus.m1_n = 1'b0;
        #1;
        chk("intack_oe", {7'b0, bus.status_oe}, 8'h00);
        bus.m1_n = 1'b1; bus.addr_lo = 8'h41;
        #1;
        chk("in_other_oe", {7'b0, bus.status_oe}, 8'h00);
        @(negedge clk);
        bus_idle();
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
